// File: rtl/w0rm_timer_scheduler.sv
// Round-robin scheduler sharing one COUNT_BITS down-counter among NUM_REQ requesters.
// Optional macro W0RM_TIMER_SCHED_ABORT_EN: owner dropping req mid-count aborts with no done pulse.

module w0rm_timer_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned COUNT_BITS = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*COUNT_BITS-1:0] req_count,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          busy
);

   localparam int unsigned        IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
   localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t                  state_q;
   logic [COUNT_BITS-1:0]   cnt_q;
   logic [NUM_REQ-1:0]      grant_q;
   logic [NUM_REQ-1:0]      done_q;
   logic                    busy_q;
   logic [IDX_W-1:0]        owner_q;
   logic [IDX_W-1:0]        last_q;

   logic                    win_found_d;
   logic [IDX_W-1:0]        win_idx_d;
   logic [COUNT_BITS-1:0]   win_cnt_d;
   int unsigned             idx;

   // Round-robin search starting just above the previous owner.
   always_comb begin
      win_found_d = 1'b0;
      win_idx_d   = '0;
      idx         = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_q) + k) % NUM_REQ;
         if (!win_found_d && req[IDX_W'(idx)]) begin
            win_found_d = 1'b1;
            win_idx_d   = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      win_cnt_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == win_idx_d) win_cnt_d = req_count[i*COUNT_BITS +: COUNT_BITS];
      end
   end

   // DONE spends one cycle raising done (grant held), then one cycle releasing grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         owner_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= '0;
               if (win_found_d) begin
                  grant_q <= ONE << win_idx_d;
                  cnt_q   <= win_cnt_d;
                  owner_q <= win_idx_d;
                  busy_q  <= 1'b1;
                  state_q <= COUNT;
               end
            end
            COUNT: begin
`ifdef W0RM_TIMER_SCHED_ABORT_EN
               if (!req[owner_q]) begin
                  grant_q <= '0;
                  last_q  <= owner_q;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else
`endif
               if (cnt_q == '0) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - COUNT_BITS'(1);
               end
            end
            DONE: begin
               if (done_q == '0) begin
                  done_q <= grant_q;
               end else begin
                  done_q  <= '0;
                  grant_q <= '0;
                  last_q  <= owner_q;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_w0rm_timer_scheduler.sv
// Scoreboard bench for w0rm_timer_scheduler: directed vectors push expected events,
// a negedge monitor pops and compares; a reactive random phase checks invariants.

module tb_w0rm_timer_scheduler;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned COUNT_BITS = 8;

   localparam int unsigned K_RISE = 0;
   localparam int unsigned K_DONE = 1;
   localparam int unsigned K_FALL = 2;

   logic                      clk   = 1'b0;
   logic                      reset = 1'b1;
   logic [NUM_REQ-1:0]        req   = '0;
   logic [NUM_REQ-1:0][7:0]   cnt_v = '0;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        done;
   logic                      busy;

   always #5 clk = ~clk;

   w0rm_timer_scheduler #(.NUM_REQ(NUM_REQ), .COUNT_BITS(COUNT_BITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_count (cnt_v),
      .grant     (grant),
      .done      (done),
      .busy      (busy)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      int unsigned kind;
      logic [3:0]  val;
   } ev_t;

   typedef struct {
      string       name;
      int unsigned act;
      int unsigned exp;
   } probe_t;

   ev_t         ev_q[$];
   probe_t      pr_q[$];
   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          sb_en  = 1'b1;
   bit          rnd_en = 1'b0;
   bit          got_done = 1'b0;
   logic [3:0]  prev_grant = '0;
   int unsigned wait_cnt[NUM_REQ];

   function automatic string kname(int unsigned k);
      case (k)
         K_RISE:  return "grant_rise";
         K_DONE:  return "done";
         default: return "grant_fall";
      endcase
   endfunction

   function automatic void push_ev(int unsigned c, int unsigned k, logic [3:0] v);
      ev_t e;
      e.cyc = c; e.kind = k; e.val = v;
      ev_q.push_back(e);
   endfunction

   function automatic void probe(string n, int unsigned a, int unsigned e);
      probe_t p;
      p.name = n; p.act = a; p.exp = e;
      pr_q.push_back(p);
   endfunction

   function automatic void chk(string n, bit ok, int unsigned act, string want);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: cyc=%0d got %0d, want %s", n, cyc, act, want);
      end
   endfunction

   function automatic void match(int unsigned k, logic [3:0] v);
      ev_t e;
      total++;
      if (ev_q.size() == 0) begin
         bad++;
         $display("FAIL sb_%s: unexpected at cyc=%0d val=%b, none expected", kname(k), cyc, v);
      end else begin
         e = ev_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.val != v) begin
            bad++;
            $display("FAIL sb_%s: got cyc=%0d val=%b, want %s cyc=%0d val=%b",
                     kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
         end
      end
   endfunction

   // Monitor: invariants, reset state, probes and scoreboard events.
   always @(negedge clk) begin
      probe_t p;
      chk("grant_onehot", $onehot0(grant), 32'(grant), "one-hot-or-zero");
      chk("done_onehot", $onehot0(done), 32'(done), "one-hot-or-zero");
      chk("done_owner", (done & ~grant) == '0, 32'(done), "subset of grant");
      if (reset) begin
         chk("rst_grant", grant == '0, 32'(grant), "0");
         chk("rst_done", done == '0, 32'(done), "0");
         chk("rst_busy", busy == 1'b0, 32'(busy), "0");
      end
      while (pr_q.size() > 0) begin
         p = pr_q.pop_front();
         chk(p.name, p.act == p.exp, p.act, $sformatf("%0d", p.exp));
      end
      if (sb_en) begin
         if (prev_grant != '0 && grant == '0) match(K_FALL, prev_grant);
         if (prev_grant == '0 && grant != '0) match(K_RISE, grant);
         if (done != '0) match(K_DONE, done);
      end
      if (rnd_en) begin
         if (prev_grant == '0 && grant != '0) begin
            got_done = 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
               if (grant[2'(i)]) wait_cnt[i] = 0;
               else if (req[2'(i)]) begin
                  wait_cnt[i]++;
                  chk($sformatf("starve_%0d", i), wait_cnt[i] < NUM_REQ, wait_cnt[i], "< NUM_REQ");
               end
            end
         end
         for (int i = 0; i < int'(NUM_REQ); i++) if (!req[2'(i)]) wait_cnt[i] = 0;
         if (done != '0) got_done = 1'b1;
         if (prev_grant != '0 && grant == '0) chk("complete", got_done, 32'(got_done), "1");
      end
      prev_grant = grant;
   end

   task automatic at_cyc(input int unsigned n);
      while (cyc < n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset(output int unsigned r);
      @(negedge clk); #1;
      reset = 1'b1;
      req   = '0;
      at_cyc(cyc + 2);
      reset = 1'b0;
      r = cyc;
   endtask

   initial begin
      int unsigned r, s, g2;
      foreach (wait_cnt[i]) wait_cnt[i] = 0;

      // Single requester 0, count 3.
      do_reset(r);
      s = r + 1;
      cnt_v[0] = 8'd3;
      req = 4'b0001;
      push_ev(s, K_RISE, 4'b0001);
      push_ev(s + 5, K_DONE, 4'b0001);
      push_ev(s + 6, K_FALL, 4'b0001);
      at_cyc(s + 2);
      probe("busy_count", 32'(busy), 1);
      at_cyc(s + 5);
      req = '0;
      at_cyc(s + 9);
      probe("busy_idle", 32'(busy), 0);

      // All four requesting with zero counts: rotation 0,1,2,3,0.
      do_reset(r);
      s = r + 1;
      cnt_v = '0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         push_ev(s + 4*k, K_RISE, 4'(1 << (k % 4)));
         push_ev(s + 4*k + 2, K_DONE, 4'(1 << (k % 4)));
         push_ev(s + 4*k + 3, K_FALL, 4'(1 << (k % 4)));
      end
      at_cyc(s + 18);
      req = '0;
      at_cyc(s + 22);

      // Requester 2: count 0, then 255 back-to-back; late count change ignored.
      do_reset(r);
      s = r + 1;
      cnt_v[2] = 8'd0;
      req = 4'b0100;
      g2 = s + 4;
      push_ev(s, K_RISE, 4'b0100);
      push_ev(s + 2, K_DONE, 4'b0100);
      push_ev(s + 3, K_FALL, 4'b0100);
      push_ev(g2, K_RISE, 4'b0100);
      push_ev(g2 + 257, K_DONE, 4'b0100);
      push_ev(g2 + 258, K_FALL, 4'b0100);
      at_cyc(s + 2);
      cnt_v[2] = 8'd255;
      at_cyc(g2 + 10);
      cnt_v[2] = 8'd5;
      at_cyc(g2 + 257);
      req = '0;
      at_cyc(g2 + 261);

      // Requester 1, count 10, req dropped after 4 COUNT cycles.
      do_reset(r);
      s = r + 1;
      cnt_v[1] = 8'd10;
      req = 4'b0010;
      push_ev(s, K_RISE, 4'b0010);
`ifdef W0RM_TIMER_SCHED_ABORT_EN
      push_ev(s + 5, K_FALL, 4'b0010);
`else
      push_ev(s + 12, K_DONE, 4'b0010);
      push_ev(s + 13, K_FALL, 4'b0010);
`endif
      at_cyc(s + 4);
      req = '0;
      at_cyc(s + 16);

      // Reset mid-COUNT on requester 3, then full count after release.
      do_reset(r);
      s = r + 1;
      cnt_v[3] = 8'd20;
      req = 4'b1000;
      push_ev(s, K_RISE, 4'b1000);
      push_ev(s + 6, K_FALL, 4'b1000);
      push_ev(s + 8, K_RISE, 4'b1000);
      push_ev(s + 30, K_DONE, 4'b1000);
      push_ev(s + 31, K_FALL, 4'b1000);
      at_cyc(s + 5);
      reset = 1'b1;
      #1;
      probe("async_rst_grant", 32'(grant), 0);
      probe("async_rst_done", 32'(done), 0);
      probe("async_rst_busy", 32'(busy), 0);
      at_cyc(s + 7);
      reset = 1'b0;
      at_cyc(s + 30);
      req = '0;
      at_cyc(s + 34);
      probe("sb_leftover", ev_q.size(), 0);

      // Reactive random traffic: req held until its done, counts 0..7.
      sb_en = 1'b0;
      do_reset(r);
      rnd_en = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk); #1;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req[2'(i)]) begin
               if (done[2'(i)] && $urandom_range(1, 0) == 0) req[2'(i)] = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
               cnt_v[2'(i)] = 8'($urandom_range(7, 0));
               req[2'(i)]   = 1'b1;
            end
         end
      end
      req = '0;
      at_cyc(cyc + 60);
      rnd_en = 1'b0;
      probe("drain_grant", 32'(grant), 0);
      probe("drain_busy", 32'(busy), 0);
      at_cyc(cyc + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
